fractal_video_out: RTL and testbench

- Output stage between the pixel pipeline (generator plus colorizer) and the AXI4-Stream video master.
- Replaces the direct wiring of the colorizer to m_axis.
- Packs PIXELS_PER_BEAT pixels per beat and buffers beats in a FIFO so downstream m_axis_tready backpressure is honoured.
- Raises an almost-full stall toward the generator and reports overflow, line-length errors and a frame counter.

---
 rtl/fractal_video_out.sv | 231 +++++++++++++++++++++++
 tb/tb_fractal_video_out.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fractal_video_out.sv
// fractal_video_out: output stage between the colorizer and the AXI4-Stream
// video master. Packs PIXELS_PER_BEAT pixels per beat and buffers beats in a
// FIFO so that m_axis_tready backpressure is honoured. It also raises an
// almost-full stall to the generator and reports overflow, line-length errors
// and a frame counter.
// Optional build macro FRACTAL_VIDEO_OUT_STATS_EN enables the stall_cycles
// counter; without it stall_cycles is tied to zero.
module fractal_video_out #(
    parameter int PIXEL_WIDTH        = 24,
    parameter int PIXELS_PER_BEAT    = 1,
    parameter int FIFO_DEPTH         = 64,
    parameter int ALMOST_FULL_MARGIN = 8,
    parameter int OUTPUT_WIDTH       = 1920
) (
    input  logic                                     aclk,
    input  logic                                     aresetn,
    input  logic                                     enable,
    input  logic [PIXEL_WIDTH-1:0]                   data_in,
    input  logic                                     frame_start_in,
    input  logic                                     line_end_in,
    input  logic                                     data_enable_in,
    output logic                                     stall_out,
    output logic                                     m_axis_tvalid,
    output logic [PIXEL_WIDTH*PIXELS_PER_BEAT-1:0]   m_axis_tdata,
    output logic [PIXEL_WIDTH*PIXELS_PER_BEAT/8-1:0] m_axis_tstrb,
    output logic                                     m_axis_tuser,
    output logic                                     m_axis_tlast,
    input  logic                                     m_axis_tready,
    output logic                                     overflow,
    output logic                                     line_error,
    output logic [15:0]                              frame_count,
    output logic [31:0]                              stall_cycles
);

    localparam int BEAT_W = PIXEL_WIDTH * PIXELS_PER_BEAT;
    localparam int STRB_W = BEAT_W / 8;
    localparam int BPP    = PIXEL_WIDTH / 8;
    localparam int SLOT_W = (PIXELS_PER_BEAT > 1) ? $clog2(PIXELS_PER_BEAT) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int PIX_W  = $clog2(OUTPUT_WIDTH) + 1;

    typedef struct packed {
        logic [BEAT_W-1:0] data;
        logic [STRB_W-1:0] strb;
        logic              user;
        logic              last;
    } beat_t;

    // Packer state
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [BEAT_W-1:0] acc_q, acc_d;
    logic              sof_q, sof_d;
    beat_t             pend_q, pend_d;
    logic              pend_valid_q, pend_valid_d;
    // Line check state
    logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d, pix_base;
    logic              line_error_q, line_error_d;
    // FIFO and output register state
    beat_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  mem_cnt_q, mem_cnt_d, fill;
    beat_t             out_q, out_d;
    logic              out_valid_q, out_valid_d;
    logic              overflow_q, overflow_d;
    logic              stall_q, stall_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;

    logic              pix_in, close_beat, full, pop, push, load;
    logic [BEAT_W-1:0] pix_shifted;
    logic [STRB_W-1:0] strb_fill;

    // Packer: place each pixel in its slot and close the beat on the last slot or line end
    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        slot_d       = slot_q;
        acc_d        = acc_q;
        sof_d        = sof_q;
        pend_d       = pend_q;
        pend_valid_d = 1'b0;
        pix_in       = enable && data_enable_in;
        close_beat   = pix_in && ((slot_q == SLOT_W'(PIXELS_PER_BEAT - 1)) || line_end_in);
        pix_shifted  = BEAT_W'(data_in) << (int'(slot_q) * PIXEL_WIDTH);
        strb_fill    = '0;
        for (int i = 0; i < PIXELS_PER_BEAT; i++) begin
            if (i <= int'(slot_q)) strb_fill[i*BPP +: BPP] = '1;
        end
        if (close_beat) begin
            pend_d.data  = acc_q | pix_shifted;
            pend_d.strb  = strb_fill;
            pend_d.user  = (slot_q == '0) ? frame_start_in : sof_q;
            pend_d.last  = line_end_in;
            pend_valid_d = 1'b1;
            slot_d       = '0;
            acc_d        = '0;
            sof_d        = 1'b0;
        end else if (pix_in) begin
            acc_d  = acc_q | pix_shifted;
            slot_d = slot_q + 1'b1;
            if (slot_q == '0) sof_d = frame_start_in;
        end
        if (!enable) begin
            slot_d = '0;
            acc_d  = '0;
            sof_d  = 1'b0;
            pend_d = '0;
        end
    end

    // Line check: count pixels per line, flag wrong lengths and misplaced frame starts
    always_comb begin
        pix_cnt_d    = pix_cnt_q;
        line_error_d = line_error_q;
        pix_base     = frame_start_in ? '0 : pix_cnt_q;
        if (pix_in) begin
            if (frame_start_in && (pix_cnt_q != '0)) line_error_d = 1'b1;
            if (line_end_in) begin
                if (pix_base != PIX_W'(OUTPUT_WIDTH - 1)) line_error_d = 1'b1;
                pix_cnt_d = '0;
            end else begin
                pix_cnt_d = pix_base + 1'b1;
            end
        end
        if (!enable) begin
            pix_cnt_d    = '0;
            line_error_d = 1'b0;
        end
    end

    // FIFO control: fill counts the memory plus the output register as one store
    always_comb begin
        fill        = mem_cnt_q + CNT_W'(out_valid_q);
        full        = (fill == CNT_W'(FIFO_DEPTH));
        pop         = out_valid_q && m_axis_tready;
        push        = pend_valid_q && (!full || pop);
        load        = (mem_cnt_q != '0) && (!out_valid_q || pop);
        wr_ptr_d    = wr_ptr_q + PTR_W'(push);
        rd_ptr_d    = rd_ptr_q + PTR_W'(load);
        mem_cnt_d   = mem_cnt_q + CNT_W'(push) - CNT_W'(load);
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (load) begin
            out_d       = mem[rd_ptr_q];
            out_valid_d = 1'b1;
        end else if (pop) begin
            out_valid_d = 1'b0;
        end
        overflow_d  = overflow_q | (pend_valid_q && full && !pop);
        stall_d     = (fill >= CNT_W'(FIFO_DEPTH - ALMOST_FULL_MARGIN));
        frame_cnt_d = frame_cnt_q + 16'(pop && out_q.user);
        if (!enable) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            mem_cnt_d   = '0;
            out_d       = '0;
            out_valid_d = 1'b0;
            overflow_d  = 1'b0;
            stall_d     = 1'b0;
            frame_cnt_d = '0;
        end
    end

    // State registers; the flush is already folded into the next-state values
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            slot_q       <= '0;
            acc_q        <= '0;
            sof_q        <= 1'b0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            pix_cnt_q    <= '0;
            line_error_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            mem_cnt_q    <= '0;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            overflow_q   <= 1'b0;
            stall_q      <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            slot_q       <= slot_d;
            acc_q        <= acc_d;
            sof_q        <= sof_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            pix_cnt_q    <= pix_cnt_d;
            line_error_q <= line_error_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            mem_cnt_q    <= mem_cnt_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            overflow_q   <= overflow_d;
            stall_q      <= stall_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    // Beat storage write port
    // NOTE: the storage array has no reset; the pointers and count define which entries are live.
    always_ff @(posedge aclk) begin
        if (push) mem[wr_ptr_q] <= pend_q;
    end

`ifdef FRACTAL_VIDEO_OUT_STATS_EN
    logic [31:0] stall_cnt_q;

    // Saturating count of cycles where a beat is offered but not taken
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)                                                  stall_cnt_q <= '0;
        else if (!enable)                                              stall_cnt_q <= '0;
        else if (out_valid_q && !m_axis_tready && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
    end

    assign stall_cycles = stall_cnt_q;
`else
    assign stall_cycles = '0;
`endif

    assign stall_out     = stall_q;
    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tdata  = out_q.data;
    assign m_axis_tstrb  = out_q.strb;
    assign m_axis_tuser  = out_q.user;
    assign m_axis_tlast  = out_q.last;
    assign overflow      = overflow_q;
    assign line_error    = line_error_q;
    assign frame_count   = frame_cnt_q;

endmodule

// File: tb/tb_fractal_video_out.sv
// Self-checking bench for fractal_video_out: one instance with one pixel per
// beat for the streaming scenarios, and one with four pixels per beat for packing.
module tb_fractal_video_out;

    logic        aclk = 1'b0, aresetn = 1'b0, enable = 1'b1;
    logic [23:0] din = '0;
    logic        fs = 1'b0, le = 1'b0, de = 1'b0, tready = 1'b0;
    logic        stall_out, m_axis_tvalid, m_axis_tuser, m_axis_tlast, overflow, line_error;
    logic [23:0] m_axis_tdata;
    logic [2:0]  m_axis_tstrb;
    logic [15:0] frame_count;
    logic [31:0] stall_cycles;

    logic [23:0] din4 = '0;
    logic        fs4 = 1'b0, le4 = 1'b0, de4 = 1'b0, tready4 = 1'b0;
    logic        stall4, tvalid4, tuser4, tlast4, ovf4, lerr4;
    logic [95:0] tdata4;
    logic [11:0] tstrb4;
    logic [15:0] fcnt4;
    logic [31:0] scyc4;

    typedef struct packed {logic [23:0] data; logic user; logic last;} exp_t;
    typedef struct packed {logic [95:0] data; logic [11:0] strb; logic user; logic last;} exp4_t;
    exp_t  exp_q[$];
    exp4_t exp4_q[$];
    exp_t  mon_e;
    int    passed = 0, total = 0, accepted = 0;

    fractal_video_out dut (
        .aclk(aclk), .aresetn(aresetn), .enable(enable), .data_in(din),
        .frame_start_in(fs), .line_end_in(le), .data_enable_in(de),
        .stall_out(stall_out), .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
        .m_axis_tstrb(m_axis_tstrb), .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(tready), .overflow(overflow), .line_error(line_error),
        .frame_count(frame_count), .stall_cycles(stall_cycles)
    );

    fractal_video_out #(.PIXELS_PER_BEAT(4), .FIFO_DEPTH(8), .ALMOST_FULL_MARGIN(2), .OUTPUT_WIDTH(6)) dut4 (
        .aclk(aclk), .aresetn(aresetn), .enable(enable), .data_in(din4),
        .frame_start_in(fs4), .line_end_in(le4), .data_enable_in(de4),
        .stall_out(stall4), .m_axis_tvalid(tvalid4), .m_axis_tdata(tdata4),
        .m_axis_tstrb(tstrb4), .m_axis_tuser(tuser4), .m_axis_tlast(tlast4),
        .m_axis_tready(tready4), .overflow(ovf4), .line_error(lerr4),
        .frame_count(fcnt4), .stall_cycles(scyc4)
    );

    always #5 aclk = ~aclk;

    // Scoreboard: a beat offered with tready high at this negedge is taken at the next posedge
    always @(negedge aclk) begin
        if (aresetn && enable && m_axis_tvalid && tready) begin
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL beat_unexpected: got data=%h user=%b last=%b, expected no beat", m_axis_tdata, m_axis_tuser, m_axis_tlast);
            end else begin
                mon_e = exp_q.pop_front();
                if (m_axis_tdata !== mon_e.data || m_axis_tuser !== mon_e.user ||
                    m_axis_tlast !== mon_e.last || m_axis_tstrb !== 3'b111)
                    $display("FAIL beat_%0d: got data=%h user=%b last=%b strb=%b, expected data=%h user=%b last=%b strb=111",
                             accepted, m_axis_tdata, m_axis_tuser, m_axis_tlast, m_axis_tstrb, mon_e.data, mon_e.user, mon_e.last);
                else passed++;
            end
            accepted++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic drive_px(input logic [23:0] d, input logic f, input logic l, input bit keep);
        din = d; fs = f; le = l; de = 1'b1;
        if (keep) exp_q.push_back('{data: d, user: f, last: l});
        @(posedge aclk); #1;
        de = 1'b0; fs = 1'b0; le = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && n < 500) begin tick(1); n++; end
        total++;
        if (exp_q.size() != 0 || m_axis_tvalid)
            $display("FAIL %s_drain: %0d beats outstanding, tvalid=%b, expected all delivered", name, exp_q.size(), m_axis_tvalid);
        else passed++;
    endtask

    task automatic flush_pulse();
        enable = 1'b0; tick(1); enable = 1'b1;
    endtask

    task automatic test_reset();
        tick(2);
        total++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || m_axis_tstrb !== '0 || m_axis_tuser !== 1'b0 || m_axis_tlast !== 1'b0)
            $display("FAIL reset_axis: got valid=%b data=%h strb=%b user=%b last=%b, expected all 0", m_axis_tvalid, m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast);
        else passed++;
        total++;
        if (stall_out !== 1'b0 || overflow !== 1'b0 || line_error !== 1'b0 || frame_count !== 16'd0 || stall_cycles !== 32'd0)
            $display("FAIL reset_status: got stall=%b ovf=%b lerr=%b fcnt=%0d scyc=%0d, expected all 0", stall_out, overflow, line_error, frame_count, stall_cycles);
        else passed++;
        aresetn = 1'b1;
        tick(2);
    endtask

    task automatic test_full_line();
        logic [23:0] p0;
        int acc0;
        tready = 1'b1;
        acc0 = accepted;
        p0 = 24'($urandom);
        drive_px(p0, 1'b1, 1'b0, 1'b1);
        total++;
        if (m_axis_tvalid !== 1'b0) $display("FAIL latency_n1: got tvalid=%b, expected 0", m_axis_tvalid); else passed++;
        drive_px(24'($urandom), 1'b0, 1'b0, 1'b1);
        total++;
        if (m_axis_tvalid !== 1'b0) $display("FAIL latency_n1b: got tvalid=%b, expected 0", m_axis_tvalid); else passed++;
        drive_px(24'($urandom), 1'b0, 1'b0, 1'b1);
        total++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== p0 || m_axis_tuser !== 1'b1)
            $display("FAIL latency_n2: got valid=%b data=%h user=%b, expected 1 %h 1", m_axis_tvalid, m_axis_tdata, m_axis_tuser, p0);
        else passed++;
        for (int i = 3; i < 1920; i++) drive_px(24'($urandom), 1'b0, 1'(i == 1919), 1'b1);
        drain("full_line");
        total++;
        if (accepted - acc0 != 1920) $display("FAIL line_beats: got %0d, expected 1920", accepted - acc0); else passed++;
        total++;
        if (line_error !== 1'b0 || frame_count !== 16'd1)
            $display("FAIL line_status: got lerr=%b fcnt=%0d, expected lerr=0 fcnt=1", line_error, frame_count);
        else passed++;
    endtask

    task automatic test_pack4();
        logic [23:0] p[6];
        exp4_t e;
        int got = 0, cyc = 0;
        for (int i = 0; i < 6; i++) p[i] = 24'($urandom);
        tready4 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            din4 = p[i]; fs4 = 1'(i == 0); le4 = 1'(i == 5); de4 = 1'b1;
            if (i == 3) exp4_q.push_back('{data: {p[3], p[2], p[1], p[0]}, strb: 12'hFFF, user: 1'b1, last: 1'b0});
            if (i == 5) exp4_q.push_back('{data: {48'h0, p[5], p[4]}, strb: 12'h03F, user: 1'b0, last: 1'b1});
            @(posedge aclk); #1;
        end
        de4 = 1'b0; fs4 = 1'b0; le4 = 1'b0;
        tick(4);
        tready4 = 1'b1;
        while (got < 2 && cyc < 20) begin
            @(negedge aclk); cyc++;
            if (tvalid4 && tready4) begin
                total++;
                if (exp4_q.size() == 0) begin
                    $display("FAIL pack4_unexpected: got data=%h, expected no beat", tdata4);
                end else begin
                    e = exp4_q.pop_front();
                    if (tdata4 !== e.data || tstrb4 !== e.strb || tuser4 !== e.user || tlast4 !== e.last)
                        $display("FAIL pack4_beat%0d: got data=%h strb=%h user=%b last=%b, expected data=%h strb=%h user=%b last=%b",
                                 got, tdata4, tstrb4, tuser4, tlast4, e.data, e.strb, e.user, e.last);
                    else passed++;
                end
                got++;
            end
        end
        tick(2);
        total++;
        if (got != 2) $display("FAIL pack4_count: got %0d beats, expected 2", got); else passed++;
        total++;
        if (lerr4 !== 1'b0 || fcnt4 !== 16'd1 || ovf4 !== 1'b0)
            $display("FAIL pack4_status: got lerr=%b fcnt=%0d ovf=%b, expected 0 1 0", lerr4, fcnt4, ovf4);
        else passed++;
    endtask

    task automatic test_backpressure();
        logic [23:0] held;
        int acc0;
        tready = 1'b0;
        for (int i = 0; i < 70; i++) begin
            drive_px(24'($urandom), 1'b0, 1'b0, 1'(i < 64));
            if (i == 56) begin total++; if (stall_out !== 1'b0) $display("FAIL stall_before: got %b, expected 0", stall_out); else passed++; end
            if (i == 57) begin total++; if (stall_out !== 1'b1) $display("FAIL stall_rise: got %b, expected 1", stall_out); else passed++; end
            if (i == 64) begin total++; if (overflow !== 1'b0) $display("FAIL ovf_before: got %b, expected 0", overflow); else passed++; end
            if (i == 65) begin total++; if (overflow !== 1'b1) $display("FAIL ovf_set: got %b, expected 1", overflow); else passed++; end
        end
        tick(3);
        total++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_q[0].data)
            $display("FAIL hold_head: got valid=%b data=%h, expected 1 %h", m_axis_tvalid, m_axis_tdata, exp_q[0].data);
        else passed++;
        held = exp_q[0].data;
        tick(5);
        total++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== held)
            $display("FAIL hold_stable: got valid=%b data=%h, expected 1 %h", m_axis_tvalid, m_axis_tdata, held);
        else passed++;
        acc0 = accepted;
        tready = 1'b1;
        drain("backpressure");
        total++;
        if (accepted - acc0 != 64) $display("FAIL bp_beats: got %0d, expected 64", accepted - acc0); else passed++;
        total++;
        if (overflow !== 1'b1 || stall_out !== 1'b0)
            $display("FAIL bp_after: got ovf=%b stall=%b, expected ovf=1 stall=0", overflow, stall_out);
        else passed++;
    endtask

    task automatic test_flush();
        tready = 1'b0;
        for (int i = 0; i < 10; i++) drive_px(24'($urandom), 1'(i == 0), 1'(i == 9), 1'b1);
        tick(3);
        total++;
        if (m_axis_tvalid !== 1'b1 || line_error !== 1'b1 || overflow !== 1'b1)
            $display("FAIL flush_pre: got valid=%b lerr=%b ovf=%b, expected 1 1 1", m_axis_tvalid, line_error, overflow);
        else passed++;
        enable = 1'b0;
        tick(1);
        total++;
        if (m_axis_tvalid !== 1'b0 || overflow !== 1'b0 || line_error !== 1'b0 || frame_count !== 16'd0 || stall_cycles !== 32'd0 || stall_out !== 1'b0)
            $display("FAIL flush_post: got valid=%b ovf=%b lerr=%b fcnt=%0d scyc=%0d stall=%b, expected all 0",
                     m_axis_tvalid, overflow, line_error, frame_count, stall_cycles, stall_out);
        else passed++;
        exp_q.delete();
        enable = 1'b1;
        tready = 1'b1;
        tick(5);
        total++;
        if (m_axis_tvalid !== 1'b0) $display("FAIL flush_empty: got tvalid=%b, expected 0", m_axis_tvalid); else passed++;
    endtask

    task automatic test_stats();
        int n = 0;
        logic [31:0] want;
        tready = 1'b0;
        drive_px(24'($urandom), 1'b0, 1'b0, 1'b1);
        while (!m_axis_tvalid && n < 10) begin tick(1); n++; end
        tick(37);
`ifdef FRACTAL_VIDEO_OUT_STATS_EN
        want = 32'd37;
`else
        want = 32'd0;
`endif
        total++;
        if (!m_axis_tvalid || stall_cycles !== want)
            $display("FAIL stall_cycles: got valid=%b count=%0d, expected valid=1 count=%0d", m_axis_tvalid, stall_cycles, want);
        else passed++;
        tready = 1'b1;
        drain("stats");
        flush_pulse();
    endtask

    task automatic test_line_error();
        tready = 1'b1;
        total++;
        if (line_error !== 1'b0) $display("FAIL lerr_start: got %b, expected 0", line_error); else passed++;
        for (int i = 0; i < 1919; i++) drive_px(24'($urandom), 1'(i == 0), 1'(i == 1918), 1'b1);
        total++;
        if (line_error !== 1'b1) $display("FAIL lerr_short_line: got %b, expected 1", line_error); else passed++;
        drain("short_line");
        flush_pulse();
        total++;
        if (line_error !== 1'b0) $display("FAIL lerr_flush_clear: got %b, expected 0", line_error); else passed++;
        for (int i = 0; i < 5; i++) drive_px(24'($urandom), 1'(i == 0), 1'b0, 1'b1);
        total++;
        if (line_error !== 1'b0) $display("FAIL lerr_midline_before: got %b, expected 0", line_error); else passed++;
        drive_px(24'($urandom), 1'b1, 1'b0, 1'b1);
        total++;
        if (line_error !== 1'b1) $display("FAIL lerr_midline_fs: got %b, expected 1", line_error); else passed++;
        for (int i = 0; i < 10; i++) drive_px(24'($urandom), 1'b0, 1'b0, 1'b1);
        drain("midline");
        total++;
        if (line_error !== 1'b1) $display("FAIL lerr_sticky: got %b, expected 1", line_error); else passed++;
        flush_pulse();
        total++;
        if (line_error !== 1'b0) $display("FAIL lerr_pulse_clear: got %b, expected 0", line_error); else passed++;
    endtask

    task automatic test_async_reset();
        tready = 1'b1;
        drive_px(24'($urandom), 1'b1, 1'b0, 1'b1);
        drain("pre_reset");
        total++;
        if (frame_count !== 16'd1) $display("FAIL areset_pre_fcnt: got %0d, expected 1", frame_count); else passed++;
        tready = 1'b0;
        for (int i = 0; i < 3; i++) drive_px(24'($urandom), 1'b0, 1'b0, 1'b1);
        tick(3);
        total++;
        if (m_axis_tvalid !== 1'b1) $display("FAIL areset_pre_valid: got %b, expected 1", m_axis_tvalid); else passed++;
        #3 aresetn = 1'b0;
        #1;
        total++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || m_axis_tstrb !== '0 || m_axis_tuser !== 1'b0 || m_axis_tlast !== 1'b0 ||
            stall_out !== 1'b0 || overflow !== 1'b0 || line_error !== 1'b0 || frame_count !== 16'd0 || stall_cycles !== 32'd0)
            $display("FAIL areset_immediate: got valid=%b data=%h strb=%b fcnt=%0d scyc=%0d, expected all 0",
                     m_axis_tvalid, m_axis_tdata, m_axis_tstrb, frame_count, stall_cycles);
        else passed++;
        exp_q.delete();
        tick(2);
        aresetn = 1'b1;
        tready = 1'b1;
        tick(4);
        total++;
        if (m_axis_tvalid !== 1'b0) $display("FAIL areset_empty: got tvalid=%b, expected 0", m_axis_tvalid); else passed++;
    endtask

    initial begin
        @(posedge aclk); #1;
        test_reset();
        test_full_line();
        test_pack4();
        test_backpressure();
        test_flush();
        test_stats();
        test_line_error();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
